// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift-sequence controller:
//   DATA_W  - operand width (32)
//   state_t - controller FSM states (IDLE, SHIFT, DONE)
//   shift_t - shift-type codes as encoded in instruction bits [6:5]
// Macro SHIFT_SEQ_RRX_EN (used by shift_seq_ctrl) selects RRX support.
// ---------------------------------------------------------------------------
package shift_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-bit shifter step.
// Ports:
//   work_in    [DATA_W-1:0]  current work value
//   shift_type shift_t       LSL / LSR / ASR / ROR
//   rrx        1             with ROR: rotate carry_in into bit31 (RRX)
//   carry_in   1             current carry (used by RRX)
//   work_out   [DATA_W-1:0]  value after one step
//   carry_out  1             bit shifted out by this step
// ---------------------------------------------------------------------------
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] work_in,
  input  shift_t            shift_type,
  input  logic              rrx,
  input  logic              carry_in,
  output logic [DATA_W-1:0] work_out,
  output logic              carry_out
);

  // One-bit shift/rotate selected by shift_type.
  always_comb begin
    work_out  = work_in;
    carry_out = carry_in;
    case (shift_type)
      SH_LSL: begin
        work_out  = {work_in[DATA_W-2:0], 1'b0};
        carry_out = work_in[DATA_W-1];
      end
      SH_LSR: begin
        work_out  = {1'b0, work_in[DATA_W-1:1]};
        carry_out = work_in[0];
      end
      SH_ASR: begin
        work_out  = {work_in[DATA_W-1], work_in[DATA_W-1:1]};
        carry_out = work_in[0];
      end
      SH_ROR: begin
        if (rrx) begin
          work_out = {carry_in, work_in[DATA_W-1:1]};
        end else begin
          work_out = {work_in[0], work_in[DATA_W-1:1]};
        end
        carry_out = work_in[0];
      end
      default: begin
        work_out  = work_in;
        carry_out = carry_in;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle second-operand generator: decodes the operand field on an
// accepted start, then performs one 1-bit shift step per cycle.
// Configuration macro: SHIFT_SEQ_RRX_EN (ROR #0 becomes a one-step RRX;
// when undefined ROR #0 is a pass-through).
// Ports:
//   clk, rst (sync, active-high)
//   start, val_rm[31:0], shift_operand[11:0], imm, mem_sel, carry_in
//   busy      - state != IDLE (pipeline freeze)
//   done      - one-cycle pulse, result/carry_out valid
//   result    - operand, held until the next accepted start
//   carry_out - shifter carry-out, held with result
// ---------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              mem_sel,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);

  state_t             state, state_next;
  logic [DATA_W-1:0]  work;
  logic [CNT_W-1:0]   cnt;
  shift_t             op_type;
  logic               op_rrx;
  logic               carry;

  logic               load;
  logic [DATA_W-1:0]  load_work;
  logic [CNT_W-1:0]   load_n;
  shift_t             load_type;
  logic               load_rrx;
  logic [4:0]         shift_imm;

  logic [DATA_W-1:0]  step_work;
  logic               step_carry;

  shift_step u_step (
    .work_in    (work),
    .shift_type (op_type),
    .rrx        (op_rrx),
    .carry_in   (carry),
    .work_out   (step_work),
    .carry_out  (step_carry)
  );

  // Operand decode: initial work value, step type and step count.
  always_comb begin
    load_work = val_rm;
    load_type = SH_LSL;
    load_n    = '0;
    load_rrx  = 1'b0;
    shift_imm = shift_operand[11:7];
    if (mem_sel) begin
      load_work = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      load_work = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
      load_type = SH_ROR;
      load_n    = CNT_W'({shift_operand[11:8], 1'b0});
    end else if (shift_operand[4]) begin
      // Register-specified shift is unsupported: pass Rm through unchanged.
      load_work = val_rm;
    end else begin
      load_type = shift_t'(shift_operand[6:5]);
      case (shift_t'(shift_operand[6:5]))
        SH_LSL: load_n = CNT_W'(shift_imm);
        SH_LSR, SH_ASR: begin
          // shift_imm of 0 encodes a 32-bit shift for LSR/ASR.
          if (shift_imm == 5'd0) begin
            load_n = CNT_W'(32'd32);
          end else begin
            load_n = CNT_W'(shift_imm);
          end
        end
        SH_ROR: begin
          if (shift_imm == 5'd0) begin
`ifdef SHIFT_SEQ_RRX_EN
            load_n   = CNT_W'(1'b1);
            load_rrx = 1'b1;
`else
            load_n   = '0;
            load_rrx = 1'b0;
`endif
          end else begin
            load_n = CNT_W'(shift_imm);
          end
        end
        default: load_n = '0;
      endcase
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (load_n == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_SHIFT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1'b1)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, status flags, work register and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      work    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      op_type <= SH_LSL;
      op_rrx  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);
      if (load) begin
        work    <= load_work;
        carry   <= carry_in;
        cnt     <= load_n;
        op_type <= load_type;
        op_rrx  <= load_rrx;
      end else if (state == ST_SHIFT) begin
        work  <= step_work;
        carry <= step_carry;
        cnt   <= cnt - CNT_W'(1'b1);
      end
    end
  end

  assign result    = work;
  assign carry_out = carry;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Directed table-driven bench for shift_seq_ctrl plus hand-written sequences
// for reset-abort and start held across DONE. Honours SHIFT_SEQ_RRX_EN for
// the ROR #0 vectors.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] val_rm;
  logic [11:0] shift_operand;
  logic        imm;
  logic        mem_sel;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        mem_sel;
    logic        imm;
    logic        cin;
    logic [11:0] so;
    logic [31:0] val;
    int          n;
    logic [31:0] res;
    logic        cout;
  } vec_t;

  vec_t vecs[$];

  shift_seq_ctrl #(.CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .val_rm        (val_rm),
    .shift_operand (shift_operand),
    .imm           (imm),
    .mem_sel       (mem_sel),
    .carry_in      (carry_in),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .carry_out     (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one operation, measure done latency, check outputs and hold.
  task automatic run_op(input int idx, input vec_t v);
    int          lat;
    logic        busy_ok;
    logic [31:0] res_done;
    @(negedge clk);
    start = 1'b1; val_rm = v.val; shift_operand = v.so;
    imm = v.imm; mem_sel = v.mem_sel; carry_in = v.cin;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.n + 1));
    check($sformatf("v%0d_busy", idx), {31'd0, busy_ok}, 32'd1);
    check($sformatf("v%0d_result", idx), result, v.res);
    check($sformatf("v%0d_carry", idx), {31'd0, carry_out}, {31'd0, v.cout});
    res_done = result;
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
    check($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_hold", idx), result, res_done);
  endtask

  initial begin
    vec_t v;
    logic seen_done;
    rst = 1'b1; start = 1'b0; val_rm = 32'd0; shift_operand = 12'd0;
    imm = 1'b0; mem_sel = 1'b0; carry_in = 1'b0;

    //                mem  imm  cin  so        val           n   res           cout
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'h2FF, 32'h0000_0000,  4, 32'hF000_000F, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h080, 32'h8000_0001,  1, 32'h0000_0002, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h040, 32'h8000_0000, 32, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 12'h800, 32'h1234_5678,  0, 32'hFFFF_F800, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 12'h7FF, 32'h1234_5678,  0, 32'h0000_07FF, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h020, 32'h8000_0000, 32, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h220, 32'h0000_001F,  4, 32'h0000_0001, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h0C0, 32'h7FFF_FFFE,  1, 32'h3FFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h010, 32'h1234_5678,  0, 32'h1234_5678, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'h0AB, 32'hFFFF_FFFF,  0, 32'h0000_00AB, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h460, 32'h1234_5678,  8, 32'h7812_3456, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h000, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'hF80, 32'h0000_0003, 31, 32'h8000_0000, 1'b1});
`ifdef SHIFT_SEQ_RRX_EN
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_0001,  1, 32'h8000_0000, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_0002,  1, 32'h8000_0001, 1'b0});
`else
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_0001,  0, 32'h0000_0001, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h060, 32'h0000_0002,  0, 32'h0000_0002, 1'b1});
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy},      32'd0);
    check("rst_done",   {31'd0, done},      32'd0);
    check("rst_result", result,             32'd0);
    check("rst_carry",  {31'd0, carry_out}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(i, vecs[i]);

    // Reset in the middle of an N=10 operation: no done, outputs cleared.
    @(negedge clk);
    start = 1'b1; val_rm = 32'h0000_0001; shift_operand = 12'h500;
    imm = 1'b0; mem_sel = 1'b0; carry_in = 1'b1;
    seen_done = 1'b0;
    @(negedge clk);                       // T+1
    start = 1'b0;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    if (done === 1'b1) seen_done = 1'b1;
    @(negedge clk);                       // T+2
    if (done === 1'b1) seen_done = 1'b1;
    @(negedge clk);                       // T+3
    if (done === 1'b1) seen_done = 1'b1;
    rst = 1'b1;
    @(negedge clk);                       // T+4
    if (done === 1'b1) seen_done = 1'b1;
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    check("abort_busy",    {31'd0, busy},      32'd0);
    check("abort_result",  result,             32'd0);
    check("abort_carry",   {31'd0, carry_out}, 32'd0);
    rst = 1'b0;
    v = '{1'b0, 1'b0, 1'b0, 12'h080, 32'h8000_0001, 1, 32'h0000_0002, 1'b1};
    run_op(100, v);                       // start at T+5

    // start held through SHIFT and DONE: re-accepted in the following IDLE.
    @(negedge clk);
    start = 1'b1; val_rm = 32'h8000_0001; shift_operand = 12'h080;
    imm = 1'b0; mem_sel = 1'b0; carry_in = 1'b0;
    @(negedge clk);                       // T+1 SHIFT
    val_rm = 32'h0000_0004;
    check("hold_t1_busy", {31'd0, busy}, 32'd1);
    check("hold_t1_done", {31'd0, done}, 32'd0);
    @(negedge clk);                       // T+2 DONE
    check("hold_t2_done",   {31'd0, done},      32'd1);
    check("hold_t2_result", result,             32'h0000_0002);
    check("hold_t2_carry",  {31'd0, carry_out}, 32'd1);
    @(negedge clk);                       // T+3 IDLE, accepts
    check("hold_t3_busy",   {31'd0, busy}, 32'd0);
    check("hold_t3_done",   {31'd0, done}, 32'd0);
    check("hold_t3_result", result,        32'h0000_0002);
    @(negedge clk);                       // T+4 SHIFT
    check("hold_t4_busy", {31'd0, busy}, 32'd1);
    check("hold_t4_done", {31'd0, done}, 32'd0);
    @(negedge clk);                       // T+5 DONE
    start = 1'b0;
    check("hold_t5_done",   {31'd0, done},      32'd1);
    check("hold_t5_result", result,             32'h0000_0008);
    check("hold_t5_carry",  {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    check("hold_t6_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
